// File: rtl/wb_regfile_stage.sv
// Writeback stage: picks ALU or RAM result, writes the 8-entry register file, counts retires/loads.
// Latency: wb_* and counters update on the commit edge; reads are combinational (new value next cycle,
// or same cycle with WB_REGFILE_BYPASS_EN defined). Backpressure: none, one writeback accepted per cycle.
// Ports: clk/reset (sync, active-low); alu_result_in, ram_rdata_in, gp_reg_wb_in, mem_re_in,
// gp_rdata2_address_in from EX/MEM-WB; rd_addr1/2 -> rd_data1/2 for decode;
// wb_valid_out/wb_addr_out/wb_data_out report the last committed write; retire_count/load_count saturate.
module wb_regfile_stage #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] ram_rdata_in,
    input  logic              gp_reg_wb_in,
    input  logic              mem_re_in,
    input  logic [ADDR_W-1:0] gp_rdata2_address_in,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wb_valid_out,
    output logic [ADDR_W-1:0] wb_addr_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic [CNT_W-1:0]  retire_count,
    output logic [CNT_W-1:0]  load_count
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] regs_q [NREG];
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
    logic [CNT_W-1:0]  load_cnt_q, load_cnt_d;
    logic [DATA_W-1:0] wb_dat;

    assign wb_dat = mem_re_in ? ram_rdata_in : alu_result_in;

    // Saturating counters: stick at all-ones instead of wrapping.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        load_cnt_d   = load_cnt_q;
        if (gp_reg_wb_in) begin
            if (retire_cnt_q != CNT_MAX) retire_cnt_d = retire_cnt_q + CNT_ONE;
            if (mem_re_in && (load_cnt_q != CNT_MAX)) load_cnt_d = load_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            retire_cnt_q <= '0;
            load_cnt_q   <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            load_cnt_q   <= load_cnt_d;
            if (gp_reg_wb_in) begin
                // Register 0 is hardwired to zero; the write is still reported and counted.
                if (gp_rdata2_address_in != '0) regs_q[gp_rdata2_address_in] <= wb_dat;
                wb_valid_q <= 1'b1;
                wb_addr_q  <= gp_rdata2_address_in;
                wb_data_q  <= wb_dat;
            end else begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
        rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
`ifdef WB_REGFILE_BYPASS_EN
        // Write-through forwarding of the writeback in flight this cycle.
        if (gp_reg_wb_in && reset && (rd_addr1 == gp_rdata2_address_in) && (rd_addr1 != '0))
            rd_data1 = wb_dat;
        if (gp_reg_wb_in && reset && (rd_addr2 == gp_rdata2_address_in) && (rd_addr2 != '0))
            rd_data2 = wb_dat;
`endif
    end

    assign wb_valid_out = wb_valid_q;
    assign wb_addr_out  = wb_addr_q;
    assign wb_data_out  = wb_data_q;
    assign retire_count = retire_cnt_q;
    assign load_count   = load_cnt_q;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Randomized + directed bench for wb_regfile_stage against an array-based reference model.
// A second instance with 3-bit counters shares the stimulus so saturation is reached quickly.
module tb_wb_regfile_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] alu_result_in, ram_rdata_in;
    logic       gp_reg_wb_in, mem_re_in;
    logic [2:0] gp_rdata2_address_in, rd_addr1, rd_addr2;
    logic [9:0] rd_data1, rd_data2, wb_data_out;
    logic       wb_valid_out;
    logic [2:0] wb_addr_out;
    logic [15:0] retire_count, load_count;

    logic [9:0] s_rd_data1, s_rd_data2, s_wb_data_out;
    logic       s_wb_valid_out;
    logic [2:0] s_wb_addr_out;
    logic [2:0] s_retire_count, s_load_count;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [9:0]  m_regs [8];
    logic        m_vld;
    logic [2:0]  m_addr;
    logic [9:0]  m_dat;
    int          m_ret, m_ld, m_sret, m_sld;

    always #5 clk = ~clk;

    wb_regfile_stage dut (
        .clk(clk), .reset(reset),
        .alu_result_in(alu_result_in), .ram_rdata_in(ram_rdata_in),
        .gp_reg_wb_in(gp_reg_wb_in), .mem_re_in(mem_re_in),
        .gp_rdata2_address_in(gp_rdata2_address_in),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_valid_out(wb_valid_out), .wb_addr_out(wb_addr_out), .wb_data_out(wb_data_out),
        .retire_count(retire_count), .load_count(load_count)
    );

    wb_regfile_stage #(.DATA_W(10), .ADDR_W(3), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset),
        .alu_result_in(alu_result_in), .ram_rdata_in(ram_rdata_in),
        .gp_reg_wb_in(gp_reg_wb_in), .mem_re_in(mem_re_in),
        .gp_rdata2_address_in(gp_rdata2_address_in),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
        .wb_valid_out(s_wb_valid_out), .wb_addr_out(s_wb_addr_out), .wb_data_out(s_wb_data_out),
        .retire_count(s_retire_count), .load_count(s_load_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] exp_rd(input logic [2:0] ra, input bit rst, input bit we,
                                          input logic [2:0] wa, input logic [9:0] wd);
        logic [9:0] v;
        v = (ra == 3'd0) ? 10'd0 : m_regs[ra];
`ifdef WB_REGFILE_BYPASS_EN
        if (we && rst && ra == wa && ra != 3'd0) v = wd;
`endif
        return v;
    endfunction

    // Called just after a rising edge: drive, check reads before the next edge,
    // advance the model across the edge, then check registered outputs.
    task automatic cycle(input bit rst, input bit we, input bit re,
                         input logic [9:0] alu, input logic [9:0] ram,
                         input logic [2:0] wa, input logic [2:0] ra1, input logic [2:0] ra2,
                         input bit do_chk);
        logic [9:0] wd;
        reset = rst; gp_reg_wb_in = we; mem_re_in = re;
        alu_result_in = alu; ram_rdata_in = ram;
        gp_rdata2_address_in = wa; rd_addr1 = ra1; rd_addr2 = ra2;
        wd = re ? ram : alu;
        #3;
        if (do_chk) begin
            check("rd_data1", {22'd0, rd_data1}, {22'd0, exp_rd(ra1, rst, we, wa, wd)});
            check("rd_data2", {22'd0, rd_data2}, {22'd0, exp_rd(ra2, rst, we, wa, wd)});
        end
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 10'd0;
            m_vld = 1'b0; m_addr = 3'd0; m_dat = 10'd0;
            m_ret = 0; m_ld = 0; m_sret = 0; m_sld = 0;
        end else if (we) begin
            if (wa != 3'd0) m_regs[wa] = wd;
            m_vld = 1'b1; m_addr = wa; m_dat = wd;
            if (m_ret < 65535) m_ret++;
            if (m_sret < 7) m_sret++;
            if (re) begin
                if (m_ld < 65535) m_ld++;
                if (m_sld < 7) m_sld++;
            end
        end else begin
            m_vld = 1'b0;
        end
        #1;
        if (do_chk) begin
            check("wb_valid", {31'd0, wb_valid_out}, {31'd0, m_vld});
            check("wb_addr", {29'd0, wb_addr_out}, {29'd0, m_addr});
            check("wb_data", {22'd0, wb_data_out}, {22'd0, m_dat});
            check("retire_count", {16'd0, retire_count}, m_ret);
            check("load_count", {16'd0, load_count}, m_ld);
            check("sat_retire", {29'd0, s_retire_count}, m_sret);
            check("sat_load", {29'd0, s_load_count}, m_sld);
        end
    endtask

    task automatic idle_read(input logic [2:0] ra1, input logic [2:0] ra2);
        cycle(1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 3'd0, ra1, ra2, 1'b1);
    endtask

    initial begin
        reset = 1'b0; gp_reg_wb_in = 1'b0; mem_re_in = 1'b0;
        alu_result_in = '0; ram_rdata_in = '0; gp_rdata2_address_in = '0;
        rd_addr1 = '0; rd_addr2 = '0;
        @(posedge clk); #1;

        // 1. Reset held for two edges, then every address reads zero.
        cycle(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 3'd0, 3'd0, 3'd0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 3'd4, 3'd0, 3'd0, 1'b1);
        for (int a = 0; a < 8; a += 2) idle_read(a[2:0], 3'(a + 1));
        check("rst_valid", {31'd0, wb_valid_out}, 32'd0);
        check("rst_retire", {16'd0, retire_count}, 32'd0);

        // 2. ALU write to r3.
        cycle(1'b1, 1'b1, 1'b0, 10'h155, 10'h2AA, 3'd3, 3'd3, 3'd0, 1'b1);
        check("t2_valid", {31'd0, wb_valid_out}, 32'd1);
        check("t2_addr", {29'd0, wb_addr_out}, 32'd3);
        check("t2_retire", {16'd0, retire_count}, 32'd1);
        check("t2_load", {16'd0, load_count}, 32'd0);
        idle_read(3'd3, 3'd3);
        check("t2_rd", {22'd0, rd_data1}, 32'h155);

        // 3. Load write to r5, then a load without write enable.
        cycle(1'b1, 1'b1, 1'b1, 10'h000, 10'h3FF, 3'd5, 3'd5, 3'd3, 1'b1);
        check("t3_load", {16'd0, load_count}, 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 10'h001, 10'h002, 3'd5, 3'd5, 3'd3, 1'b1);
        check("t3_noval", {31'd0, wb_valid_out}, 32'd0);
        check("t3_r5", {22'd0, rd_data1}, 32'h3FF);
        check("t3_loadhold", {16'd0, load_count}, 32'd1);

        // 4. Write to r0 is discarded but reported and counted.
        cycle(1'b1, 1'b1, 1'b0, 10'h1A5, 10'h000, 3'd0, 3'd0, 3'd0, 1'b1);
        check("t4_addr", {29'd0, wb_addr_out}, 32'd0);
        check("t4_retire", {16'd0, retire_count}, 32'd3);
        idle_read(3'd0, 3'd0);
        check("t4_r0", {22'd0, rd_data1}, 32'd0);

        // 5. Same-cycle read of r6 while it is being written.
        cycle(1'b1, 1'b1, 1'b0, 10'h011, 10'h000, 3'd6, 3'd1, 3'd2, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 10'h0F0, 10'h000, 3'd6, 3'd6, 3'd6, 1'b1);
        idle_read(3'd6, 3'd5);
        check("t5_after", {22'd0, rd_data1}, 32'h0F0);

        // 6. Drive the narrow counters into saturation, then reset together with a commit.
        for (int k = 0; k < 10; k++)
            cycle(1'b1, 1'b1, 1'b1, 10'(k), 10'(k + 100), 3'(k), 3'(k), 3'(k + 1), 1'b1);
        check("t6_sat_ret", {29'd0, s_retire_count}, 32'd7);
        check("t6_sat_ld", {29'd0, s_load_count}, 32'd7);
        cycle(1'b0, 1'b1, 1'b0, 10'h2B2, 10'h000, 3'd2, 3'd2, 3'd0, 1'b1);
        check("t6_rst_ret", {16'd0, retire_count}, 32'd0);
        for (int a = 0; a < 8; a += 2) idle_read(a[2:0], 3'(a + 1));

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++)
            cycle(($urandom_range(0, 39) != 0), $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  10'($urandom), 10'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
